// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider for unsigned operands.
// The start/busy/done handshake works like this. start is sampled only at an
// edge where busy=0, which means the IDLE or DONE state. The operands are
// captured at that same edge. busy stays high for the WIDTH iterations. done
// pulses for one cycle when quotient/remainder/div_by_zero are updated.
// Starts that arrive while busy are dropped.
// A zero divisor skips the iterations and reports in the next cycle.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic             last_iter;
  logic             accept;

  // One iteration step. The partial remainder is widened by one bit so that
  // 2R+1 cannot overflow. The borrow (trial MSB) decides between keeping the
  // shifted remainder (restore) and taking the difference.
  always_comb begin
    r_shift   = {r_acc, q_acc[WIDTH-1]};
    trial     = r_shift - {1'b0, dvs};
    q_next    = {q_acc[WIDTH-2:0], ~trial[WIDTH]};
    r_next    = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    last_iter = (count == CW'(WIDTH - 1));
    accept    = start && (state != RUN);
  end

  // Next-state logic. DONE accepts a new start just as IDLE does, which gives
  // back-to-back throughput.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (divisor == '0) ? DONE : RUN;
        else        state_next = IDLE;
      end
      RUN:     if (last_iter) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State register. An asynchronous reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath. The working registers iterate during RUN. The result registers
  // change only at DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_acc       <= '0;
      r_acc       <= '0;
      dvs         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dvs   <= divisor;
        q_acc <= dividend;
        r_acc <= '0;
        count <= '0;
      end
    end else if (state == RUN) begin
      q_acc <= q_next;
      r_acc <= r_next;
      count <= count + 1'b1;
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

  // Status outputs decode the registered state only, so there is no path
  // from the inputs to the outputs.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider (WIDTH=8). Each issued operation pushes its
// expected result and timing into a queue. A negedge monitor pops the queue
// and compares on every done pulse, and also checks busy on every cycle.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           scyc;
    int           dcyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Clock and cycle counter. cyc increments on every rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drives start for one cycle, called at a negedge. The next rising edge is
  // the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    e.scyc = cyc + 1;
    e.dcyc = (b == '0) ? e.scyc : e.scyc + W;
    exp_q.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
  endtask

  // Drives start for one cycle while the DUT is busy. It must be ignored.
  task automatic poke(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits, with a bound, until every expected result has been seen.
  task automatic wait_idle();
    for (int i = 0; i < 4 * W && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: checks busy every cycle and the result on every done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic eb;
    if (rst_n) begin
      eb = 1'b0;
      if (exp_q.size() != 0)
        if (!exp_q[0].dz && cyc >= exp_q[0].scyc && cyc < exp_q[0].scyc + W) eb = 1'b1;
      chk("busy", busy, eb);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("done_busy", busy, 0);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dz);
          if (!e.dz) begin
            chk("invariant", longint'(quotient) * e.b + remainder, e.a);
            chk("rem_lt_div", remainder < e.b, 1);
          end
        end
      end
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[5] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, dz: 1'b1};
    vecs[6] = '{a: 8'd40,  b: 8'd8,   q: 8'd5,   r: 8'd0,  dz: 1'b0};

    // Reset
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, including the boundaries and a divide by zero
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
      wait_idle();
    end

    // A start while busy is ignored, then a start in the done cycle is accepted
    issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
    repeat (2) @(negedge clk);
    poke(8'd9, 8'd2);
    begin
      int k;
      for (k = 0; k < 2 * W; k++) begin
        @(negedge clk);
        if (done) break;
      end
      chk("b2b_done_seen", k < 2 * W, 1);
    end
    issue(8'd9, 8'd2, 8'd4, 8'd1, 1'b0);
    wait_idle();

    // Asynchronous reset between edges, partway through an operation
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
    wait_idle();

    // Random regression
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      if (b == '0) issue(a, b, '1, a, 1'b1);
      else         issue(a, b, a / b, a % b, 1'b0);
      if ($urandom_range(0, 1) == 1) wait_idle();
      else begin
        for (int k = 0; k < 2 * W && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
          n_checks++; n_errors++;
          $display("FAIL rand_timeout pending=%0d expected=0", exp_q.size());
          exp_q.delete();
        end
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
